// File: rtl/diferential_cfg_loader.sv
// Serial cell-configuration loader for the muxpga grid: shadows a full image, commits it atomically, then settles and releases the grid.
// Optional per-beat parity checking is enabled with `define CFG_PARITY_EN.
module diferential_cfg_loader #(
  parameter int ROWS          = 5,
  parameter int COLS          = 5,
  parameter int CFG_W         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [CFG_W-1:0]            cfg_nibble,
  input  logic                        cfg_valid,
  input  logic                        cfg_par,
  output logic                        cfg_ready,
  output logic [ROWS*COLS*CFG_W-1:0]  cell_cfg,
  output logic                        grid_run,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_ERROR
  } state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CELLS*CFG_W-1:0]   shadow_q, shadow_d;
  logic [CELLS*CFG_W-1:0]   cell_cfg_q, cell_cfg_d;
  logic                     from_run_q, from_run_d;
  logic                     cfg_ready_q, cfg_ready_d;
  logic                     grid_run_q, grid_run_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     parity_bad;

`ifdef CFG_PARITY_EN
  assign parity_bad = (cfg_par != ^cfg_nibble);
`else
  logic unused_par;
  assign unused_par = cfg_par;
  assign parity_bad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    cell_cfg_d = cell_cfg_q;
    from_run_d = from_run_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          idx_d      = '0;
          from_run_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (cfg_valid && cfg_ready_q) begin
          if (parity_bad) begin
            state_d    = S_ERROR;
            idx_d      = '0;
            from_run_d = 1'b0;
            err_d      = 1'b1;
          end else begin
            shadow_d[idx_q*CFG_W +: CFG_W] = cfg_nibble;
            // The final beat bypasses the shadow so the whole image lands in one edge.
            if (idx_q == IDX_W'(CELLS-1)) begin
              cell_cfg_d = shadow_d;
              idx_d      = '0;
              cnt_d      = CNT_W'(SETTLE_CYCLES-1);
              state_d    = S_SETTLE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d    = S_RUN;
          from_run_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RUN: begin
        if (start) begin
          state_d    = S_LOAD;
          idx_d      = '0;
          from_run_d = 1'b1;
        end
      end
      S_ERROR: begin
        if (start) begin
          state_d    = S_LOAD;
          idx_d      = '0;
          from_run_d = 1'b0;
          err_d      = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are derived from the next state so they register alongside it.
    cfg_ready_d = (state_d == S_LOAD);
    busy_d      = (state_d == S_LOAD) || (state_d == S_SETTLE);
    grid_run_d  = (state_d == S_RUN) || ((state_d == S_LOAD) && from_run_d);
    done_d      = (state_q == S_SETTLE) && (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      cell_cfg_q  <= '0;
      from_run_q  <= 1'b0;
      cfg_ready_q <= 1'b0;
      grid_run_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      cell_cfg_q  <= cell_cfg_d;
      from_run_q  <= from_run_d;
      cfg_ready_q <= cfg_ready_d;
      grid_run_q  <= grid_run_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cell_cfg  = cell_cfg_q;
  assign grid_run  = grid_run_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_diferential_cfg_loader.sv
// Directed self-checking bench for diferential_cfg_loader (5x5 grid, 4-bit cells, 2 settle cycles).
// The parity scenario is compiled in only when CFG_PARITY_EN is defined.
module tb_diferential_cfg_loader;

  localparam int CELLS = 25;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   cfg_nibble;
  logic         cfg_valid;
  logic         cfg_par;
  logic         cfg_ready;
  logic [99:0]  cell_cfg;
  logic         grid_run;
  logic         busy;
  logic         done;
  logic         err;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [3:0]   img [CELLS];
  logic [99:0]  old_cfg;
  logic [99:0]  new_cfg;
  logic [99:0]  all_f;

  diferential_cfg_loader #(
    .ROWS(5), .COLS(5), .CFG_W(4), .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_nibble(cfg_nibble), .cfg_valid(cfg_valid), .cfg_par(cfg_par),
    .cfg_ready(cfg_ready), .cell_cfg(cell_cfg), .grid_run(grid_run),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic run_exp);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start_ready", cfg_ready, 1'b1);
    checkOutput("start_busy", busy, 1'b1);
    checkOutput("start_run", grid_run, run_exp);
  endtask

  task automatic observe_load(input logic run_exp);
    checkOutput("load_ready", cfg_ready, 1'b1);
    checkOutput("load_busy", busy, 1'b1);
    checkOutput("load_run", grid_run, run_exp);
    checkOutput("load_cfg_hold", cell_cfg, old_cfg);
    checkOutput("load_done", done, 1'b0);
  endtask

  // Feeds img[] from the LOAD state, then checks commit, settle and the done pulse.
  task automatic applyStimulus(input int gap, input logic run_exp, input logic start_held);
    int ready_cycles;
    ready_cycles = 0;
    for (int i = 0; i < CELLS; i++) new_cfg[i*4 +: 4] = img[i];
    for (int i = 0; i < CELLS; i++) begin
      if (gap != 0) begin
        cfg_valid = 1'b0;
        observe_load(run_exp);
        if (cfg_ready) ready_cycles++;
        tick();
      end
      cfg_valid  = 1'b1;
      cfg_nibble = img[i];
      cfg_par    = ^img[i];
      observe_load(run_exp);
      if (cfg_ready) ready_cycles++;
      tick();
    end
    cfg_valid = 1'b0;
    checkOutput("ready_cycles", ready_cycles, (gap != 0) ? 50 : 25);
    checkOutput("commit_cfg", cell_cfg, new_cfg);
    checkOutput("settle1_run", grid_run, 1'b0);
    checkOutput("settle1_busy", busy, 1'b1);
    checkOutput("settle1_ready", cfg_ready, 1'b0);
    checkOutput("settle1_done", done, 1'b0);
    old_cfg = new_cfg;
    tick();
    checkOutput("settle2_run", grid_run, 1'b0);
    checkOutput("settle2_busy", busy, 1'b1);
    checkOutput("settle2_done", done, 1'b0);
    tick();
    checkOutput("run_grid", grid_run, 1'b1);
    checkOutput("run_done", done, 1'b1);
    checkOutput("run_busy", busy, 1'b0);
    checkOutput("run_ready", cfg_ready, 1'b0);
    checkOutput("run_cfg", cell_cfg, old_cfg);
    checkOutput("run_err", err, 1'b0);
    if (!start_held) begin
      tick();
      checkOutput("run2_done", done, 1'b0);
      checkOutput("run2_grid", grid_run, 1'b1);
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_nibble = 4'h0;
    cfg_par    = 1'b0;
    old_cfg    = '0;
    new_cfg    = '0;
    all_f      = {25{4'hF}};

    tick();
    tick();
    checkOutput("rst_ready", cfg_ready, 1'b0);
    checkOutput("rst_cfg", cell_cfg, 100'h0);
    checkOutput("rst_run", grid_run, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    reset = 1'b0;
    tick();
    checkOutput("idle_ready", cfg_ready, 1'b0);
    checkOutput("idle_busy", busy, 1'b0);

    $display("[TB] scenario 1: back-to-back load of i%%16");
    for (int i = 0; i < CELLS; i++) img[i] = 4'(i % 16);
    pulse_start(1'b0);
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("a_cell24", cell_cfg[99:96], 4'h8);
    checkOutput("a_cell0", cell_cfg[3:0], 4'h0);
    checkOutput("a_cell15", cell_cfg[63:60], 4'hF);
    checkOutput("a_cell16", cell_cfg[67:64], 4'h0);

    $display("[TB] scenario 2: same load with valid gaps, reloaded from RUN");
    pulse_start(1'b1);
    applyStimulus(1, 1'b1, 1'b0);
    checkOutput("gap_cell24", cell_cfg[99:96], 4'h8);

    $display("[TB] scenario 3: reload all-F image while grid runs image A");
    for (int i = 0; i < CELLS; i++) img[i] = 4'hF;
    pulse_start(1'b1);
    applyStimulus(0, 1'b1, 1'b0);
    checkOutput("b_all_f", cell_cfg, all_f);

    $display("[TB] scenario 4: async reset after 10 beats");
    for (int i = 0; i < CELLS; i++) img[i] = 4'((i * 3 + 1) % 16);
    pulse_start(1'b1);
    for (int i = 0; i < 10; i++) begin
      cfg_valid  = 1'b1;
      cfg_nibble = img[i];
      cfg_par    = ^img[i];
      tick();
    end
    cfg_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_cfg", cell_cfg, 100'h0);
    checkOutput("arst_ready", cfg_ready, 1'b0);
    checkOutput("arst_busy", busy, 1'b0);
    checkOutput("arst_run", grid_run, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("arst_idle_ready", cfg_ready, 1'b0);
    old_cfg = '0;
    pulse_start(1'b0);
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("c_cell0", cell_cfg[3:0], 4'h1);
    checkOutput("c_cell1", cell_cfg[7:4], 4'h4);
    checkOutput("c_cell24", cell_cfg[99:96], 4'h9);

`ifdef CFG_PARITY_EN
    $display("[TB] scenario 5: parity error on beat 3");
    pulse_start(1'b1);
    for (int i = 0; i < 3; i++) begin
      cfg_valid  = 1'b1;
      cfg_nibble = img[i];
      cfg_par    = ^img[i];
      tick();
    end
    cfg_valid  = 1'b1;
    cfg_nibble = img[3];
    cfg_par    = ~(^img[3]);
    tick();
    cfg_valid = 1'b0;
    checkOutput("par_err", err, 1'b1);
    checkOutput("par_ready", cfg_ready, 1'b0);
    checkOutput("par_run", grid_run, 1'b0);
    checkOutput("par_busy", busy, 1'b0);
    checkOutput("par_cfg", cell_cfg, old_cfg);
    tick();
    checkOutput("par_err_sticky", err, 1'b1);
    pulse_start(1'b0);
    checkOutput("par_err_clear", err, 1'b0);
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("par_cell24", cell_cfg[99:96], 4'h9);
`endif

    $display("[TB] scenario 6: start held high through LOAD and SETTLE");
    for (int i = 0; i < CELLS; i++) img[i] = 4'(15 - (i % 16));
    start = 1'b1;
    tick();
    checkOutput("hold_ready", cfg_ready, 1'b1);
    checkOutput("hold_run", grid_run, 1'b1);
    applyStimulus(0, 1'b1, 1'b1);
    checkOutput("hold_cell0", cell_cfg[3:0], 4'hF);
    checkOutput("hold_cell24", cell_cfg[99:96], 4'h7);
    tick();
    checkOutput("hold_reload_ready", cfg_ready, 1'b1);
    checkOutput("hold_reload_busy", busy, 1'b1);
    checkOutput("hold_reload_run", grid_run, 1'b1);
    checkOutput("hold_reload_done", done, 1'b0);
    start = 1'b0;
    tick();
    checkOutput("hold_final_cfg", cell_cfg, old_cfg);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
